formacao_inimigos: RTL and testbench
====================================

FORMACAO_INIMIGOS -- requirements
Module: formacao_inimigos

Interface
REQ-001 SHALL have parameter COLS, default 8, formation columns (1..16).
REQ-002 SHALL have parameter ROWS, default 4, formation rows (1..8); N = COLS*ROWS.
REQ-003 SHALL have parameters LARGURA 30 and ALTURA 30, enemy size in px.
REQ-004 SHALL have parameters ESP_X 10 and ESP_Y 10, gap between enemies in px.
REQ-005 SHALL have parameters PASSO_X 20 and PASSO_Y 20, step sizes in px.
REQ-006 SHALL have parameters DIV_INI 25000000, DIV_MIN 2500000 and DIV_DEC 500000, step period in clocks, its floor, and the decrement per kill.
REQ-007 SHALL have parameters X_INI 40, Y_INI 40 and LIMITE_Y 440, the reset origin and the invasion line.
REQ-008 SHALL have ports in this order:
- CLOCK_50  in  1  system clock, single domain
- reset  in  1  asynchronous, active-high
- pausa  in  1  freeze motion and hits
- reiniciarJogo  in  1  synchronous restart
- xi, yi  in  10 each  restart origin
- acerto  in  1  one-cycle kill strobe
- acertoIdx  in  $clog2(N)  killed enemy, index = row*COLS+col
- x, y  out  10 each  formation origin (top-left of col 0, row 0)
- vivos  out  N  alive mask
- passo  out  1  one-cycle pulse on every move
- formacaoVazia  out  1  vivos == 0
- chegouFundo  out  1  sticky invasion flag

Function
REQ-009 The block SHALL be fully synchronous to CLOCK_50; no derived clocks.
REQ-010 A tick counter SHALL count 0..divAtual-1 and assert internal tick at terminal count, then wrap to 0.
REQ-011 On tick, when not paused, not empty and not chegouFundo, the block SHALL perform exactly one move and pulse passo for that cycle.
REQ-012 Extents SHALL be computed from vivos: colEsq/colDir are the lowest/highest columns with any live enemy; rowBaixo is the highest row with any live enemy.
REQ-013 The edge tests SHALL use 11-bit arithmetic with no wrap:
- bordaEsq = x + colEsq*(LARGURA+ESP_X)
- bordaDir = x + colDir*(LARGURA+ESP_X) + LARGURA
REQ-014 Moving right with bordaDir + PASSO_X > 640, or moving left with bordaEsq < PASSO_X, SHALL trigger a descend: y += PASSO_Y, direction inverts, and x is unchanged that tick.
REQ-015 Otherwise the move SHALL be x += PASSO_X (right) or x -= PASSO_X (left).
REQ-016 After each move, if y + rowBaixo*(ALTURA+ESP_Y) + ALTURA >= LIMITE_Y, chegouFundo SHALL set and remain set until reset or restart.
REQ-017 acerto with vivos[acertoIdx]=1 and pausa=0 SHALL clear that bit on the next edge.
REQ-018 Each kill SHALL set divAtual = max(divAtual - DIV_DEC, DIV_MIN); the tick counter is not reset.
REQ-019 acerto on a dead enemy, with acertoIdx >= N, or while pausa=1 SHALL be ignored: no mask or divider change.
REQ-020 When acerto and tick coincide, the move SHALL use the pre-kill mask, and the kill SHALL apply in the same cycle.
REQ-021 pausa=1 SHALL hold the counter, x, y, direction and mask.
REQ-022 formacaoVazia SHALL be combinational from vivos; when it is 1, motion stops.
REQ-023 reiniciarJogo SHALL synchronously load x=xi, y=yi, direction right, vivos all ones, divAtual=DIV_INI, counter 0, chegouFundo 0, passo 0, with priority over all other inputs.

Reset
REQ-024 Asserting reset SHALL asynchronously force:
- x=X_INI, y=Y_INI
- direction right, vivos all ones
- divAtual=DIV_INI, counter 0
- passo 0, chegouFundo 0
REQ-025 Reset asserted mid-step SHALL discard the pending move; the first tick after release SHALL occur DIV_INI clocks later.

Structure
REQ-026 TELA_W=640, TELA_H=480 and the direction encoding (DIR_DIR=1, DIR_ESQ=0) SHALL live in shared package jogo_pkg, used by all sprite blocks.
REQ-027 The extent reduction (colEsq, colDir, rowBaixo from vivos) SHALL be sub-module extremos_formacao, combinational and parametrised by COLS and ROWS.

Verification (DIV_INI=4, DIV_MIN=2, DIV_DEC=1, COLS=4, ROWS=2, X_INI=40, Y_INI=40)
REQ-028 Release reset, idle -> passo every 4 clocks; x = 60, 80, 100, ...; y = 40.
REQ-029 Run until bordaDir + 20 > 640 -> that tick y=60 and x unchanged; next tick x decreases by 20.
REQ-030 Kill all of columns 3 and 2 -> right reversal occurs 80 px further right than with the full formation.
REQ-031 Three kills -> passo period 4, 3, 2, 2 clocks; a repeated kill of the same index leaves the period unchanged.
REQ-032 acerto coincident with tick on col 3 at the right boundary -> descend still taken; vivos bit clears the same cycle.
REQ-033 Drive y until the bottom row reaches 440 -> chegouFundo=1 and motion halts; pausa mid-count freezes all; async reset mid-count -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/jogo_pkg.sv
// ============================================================================
//  Module      : jogo_pkg
//  Description : Definitions shared by all sprite blocks of the game: the
//                screen size and the horizontal direction encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jogo_pkg;

  localparam int TELA_W = 640;
  localparam int TELA_H = 480;

  // Horizontal direction of motion; 1 = moving right, 0 = moving left.
  typedef enum logic {
    DIR_ESQ = 1'b0,
    DIR_DIR = 1'b1
  } dir_t;

endpackage

`default_nettype wire

// File: rtl/extremos_formacao.sv
// ============================================================================
//  Module      : extremos_formacao
//  Description : Combinational extent reduction of the alive mask.
//  Ports       : vivos     - alive mask, bit index = row*COLS + col
//                col_esq   - lowest column holding a live enemy
//                col_dir   - highest column holding a live enemy
//                row_baixo - highest row holding a live enemy
//                All three outputs are 0 when the mask is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module extremos_formacao #(
  parameter int COLS  = 8,
  parameter int ROWS  = 4,
  parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [COLS*ROWS-1:0] vivos,
  output logic [COL_W-1:0]     col_esq,
  output logic [COL_W-1:0]     col_dir,
  output logic [ROW_W-1:0]     row_baixo
);

  logic [COLS-1:0] col_vivo;
  logic [ROWS-1:0] row_vivo;

  always_comb begin
    col_vivo  = '0;
    row_vivo  = '0;
    col_esq   = '0;
    col_dir   = '0;
    row_baixo = '0;

    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (vivos[r*COLS + c]) begin
          col_vivo[c] = 1'b1;
          row_vivo[r] = 1'b1;
        end
      end
    end

    // Scanning downwards leaves the lowest live column as the last hit.
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_vivo[c]) col_esq = COL_W'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_vivo[c]) col_dir = COL_W'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_vivo[r]) row_baixo = ROW_W'(r);
    end
  end

endmodule

`default_nettype wire

// File: rtl/formacao_inimigos.sv
// ============================================================================
//  Module      : formacao_inimigos
//  Description : Enemy formation controller. Steps the formation origin
//                sideways on every divider tick, descends and reverses at the
//                screen edges, removes killed enemies, speeds up per kill and
//                flags when the lowest live row reaches the invasion line.
//  Ports       : CLOCK_50      - system clock
//                reset         - asynchronous active-high reset
//                pausa         - freeze counter, motion and hits
//                reiniciarJogo - synchronous restart at origin (xi, yi)
//                acerto        - one-cycle kill strobe for acertoIdx
//                x, y          - formation origin (col 0, row 0 top-left)
//                vivos         - alive mask
//                passo         - one-cycle pulse after every move
//                formacaoVazia - no enemy left
//                chegouFundo   - sticky invasion flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module formacao_inimigos
  import jogo_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int ROWS     = 4,
  parameter int LARGURA  = 30,
  parameter int ALTURA   = 30,
  parameter int ESP_X    = 10,
  parameter int ESP_Y    = 10,
  parameter int PASSO_X  = 20,
  parameter int PASSO_Y  = 20,
  parameter int DIV_INI  = 25000000,
  parameter int DIV_MIN  = 2500000,
  parameter int DIV_DEC  = 500000,
  parameter int X_INI    = 40,
  parameter int Y_INI    = 40,
  parameter int LIMITE_Y = 440,
  localparam int N       = COLS * ROWS,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             pausa,
  input  logic             reiniciarJogo,
  input  logic [9:0]       xi,
  input  logic [9:0]       yi,
  input  logic             acerto,
  input  logic [IDX_W-1:0] acertoIdx,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic [N-1:0]     vivos,
  output logic             passo,
  output logic             formacaoVazia,
  output logic             chegouFundo
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(DIV_INI + 1);

  localparam logic [CNT_W-1:0] C_DIV_INI = CNT_W'(DIV_INI);
  localparam logic [CNT_W-1:0] C_DIV_MIN = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] C_DIV_DEC = CNT_W'(DIV_DEC);

  localparam logic [10:0] C_PITCH_X = 11'(LARGURA + ESP_X);
  localparam logic [10:0] C_PITCH_Y = 11'(ALTURA + ESP_Y);
  localparam logic [10:0] C_LARG    = 11'(LARGURA);
  localparam logic [10:0] C_ALT     = 11'(ALTURA);
  localparam logic [10:0] C_PX11    = 11'(PASSO_X);
  localparam logic [10:0] C_TELA_W  = 11'(TELA_W);
  localparam logic [10:0] C_LIM_Y   = 11'(LIMITE_Y);
  localparam logic [9:0]  C_PX10    = 10'(PASSO_X);
  localparam logic [9:0]  C_PY10    = 10'(PASSO_Y);

  logic [9:0]       x_q, x_d, y_q, y_d;
  dir_t             dir_q, dir_d;
  logic [N-1:0]     vivos_q, vivos_d;
  logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic             passo_q, passo_d;
  logic             fundo_q, fundo_d;

  logic [COL_W-1:0] col_esq, col_dir;
  logic [ROW_W-1:0] row_baixo;
  logic [10:0]      borda_esq, borda_dir;
  logic             vazia, tick, mover, acerto_ok, bate;

  extremos_formacao #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_extremos (
    .vivos     (vivos_q),
    .col_esq   (col_esq),
    .col_dir   (col_dir),
    .row_baixo (row_baixo)
  );

  assign vazia     = (vivos_q == '0);
  // ">=" rather than "==" so a kill that drops the divider below the current
  // count still produces a tick instead of running the counter to wrap.
  assign tick      = (cnt_q >= (div_q - CNT_W'(1)));
  assign mover     = tick && !pausa && !vazia && !fundo_q;
  assign acerto_ok = acerto && !pausa && ($unsigned(acertoIdx) < N) && vivos_q[acertoIdx];

  assign borda_esq = {1'b0, x_q} + 11'(col_esq) * C_PITCH_X;
  assign borda_dir = {1'b0, x_q} + 11'(col_dir) * C_PITCH_X + C_LARG;
  assign bate      = ((dir_q == DIR_DIR) && (borda_dir + C_PX11 > C_TELA_W)) ||
                     ((dir_q == DIR_ESQ) && (borda_esq < C_PX11));

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    vivos_d = vivos_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    passo_d = 1'b0;
    fundo_d = fundo_q;

    if (reiniciarJogo) begin
      x_d     = xi;
      y_d     = yi;
      dir_d   = DIR_DIR;
      vivos_d = '1;
      div_d   = C_DIV_INI;
      cnt_d   = '0;
      fundo_d = 1'b0;
    end else if (!pausa) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

      // Move decisions use the pre-kill mask so a coincident kill cannot
      // cancel a reversal that was already due.
      if (mover) begin
        passo_d = 1'b1;
        if (bate) begin
          y_d   = y_q + C_PY10;
          dir_d = (dir_q == DIR_DIR) ? DIR_ESQ : DIR_DIR;
        end else if (dir_q == DIR_DIR) begin
          x_d = x_q + C_PX10;
        end else begin
          x_d = x_q - C_PX10;
        end
        if (({1'b0, y_d} + 11'(row_baixo) * C_PITCH_Y + C_ALT) >= C_LIM_Y) begin
          fundo_d = 1'b1;
        end
      end

      if (acerto_ok) begin
        vivos_d[acertoIdx] = 1'b0;
        div_d = (int'(div_q) >= DIV_MIN + DIV_DEC) ? div_q - C_DIV_DEC : C_DIV_MIN;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x_q     <= 10'(X_INI);
      y_q     <= 10'(Y_INI);
      dir_q   <= DIR_DIR;
      vivos_q <= '1;
      div_q   <= C_DIV_INI;
      cnt_q   <= '0;
      passo_q <= 1'b0;
      fundo_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      vivos_q <= vivos_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      passo_q <= passo_d;
      fundo_q <= fundo_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign vivos         = vivos_q;
  assign passo         = passo_q;
  assign formacaoVazia = vazia;
  assign chegouFundo   = fundo_q;

endmodule

`default_nettype wire

// File: tb/tb_formacao_inimigos.sv
// ============================================================================
//  Module      : tb_formacao_inimigos
//  Description : Directed self-checking bench for formacao_inimigos with a
//                small 4x2 formation and a 4-clock initial step period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_formacao_inimigos;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pausa = 1'b0;
  logic       reiniciar = 1'b0;
  logic       acerto = 1'b0;
  logic [9:0] xi = '0;
  logic [9:0] yi = '0;
  logic [2:0] idx = '0;
  logic [9:0] x, y;
  logic [7:0] vivos;
  logic       passo, vazia, fundo;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  formacao_inimigos #(
    .COLS    (4),
    .ROWS    (2),
    .DIV_INI (4),
    .DIV_MIN (2),
    .DIV_DEC (1),
    .X_INI   (40),
    .Y_INI   (40)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .pausa         (pausa),
    .reiniciarJogo (reiniciar),
    .xi            (xi),
    .yi            (yi),
    .acerto        (acerto),
    .acertoIdx     (idx),
    .x             (x),
    .y             (y),
    .vivos         (vivos),
    .passo         (passo),
    .formacaoVazia (vazia),
    .chegouFundo   (fundo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges until passo is seen.
  task automatic wait_passo(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!passo && cyc < 64);
    if (!passo) begin
      n_checks++;
      n_errors++;
      $display("FAIL passo_timeout: got no passo within %0d cycles", cyc);
    end
  endtask

  task automatic kill(input int i);
    idx    = 3'(i);
    acerto = 1'b1;
    @(negedge clk);
    acerto = 1'b0;
  endtask

  task automatic restart(input int xv, input int yv);
    xi        = 10'(xv);
    yi        = 10'(yv);
    reiniciar = 1'b1;
    @(negedge clk);
    reiniciar = 1'b0;
  endtask

  task automatic expect_idle(input string tag, input int cyc);
    int p = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (passo) p++;
    end
    check(tag, p, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Asynchronous reset, sampled before the first clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_x", x, 40);
    check("rst_y", y, 40);
    check("rst_vivos", vivos, 8'hFF);
    check("rst_passo", passo, 0);
    check("rst_fundo", fundo, 0);
    check("rst_vazia", vazia, 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle stepping right every 4 clocks.
    wait_passo(n);
    check("first_period", n, 4);
    check("step1_x", x, 60);
    check("step1_y", y, 40);
    wait_passo(n);
    check("step2_period", n, 4);
    check("step2_x", x, 80);
    wait_passo(n);
    check("step3_x", x, 100);

    // Right edge with full formation: reversal at x=480.
    repeat (19) wait_passo(n);
    check("pre_edge_x", x, 480);
    check("pre_edge_y", y, 40);
    wait_passo(n);
    check("desc_x", x, 480);
    check("desc_y", y, 60);
    wait_passo(n);
    check("left_x", x, 460);
    check("left_y", y, 60);

    // Columns 2 and 3 removed: reversal 80 px further right.
    restart(40, 40);
    check("restart_x", x, 40);
    check("restart_vivos", vivos, 8'hFF);
    kill(2); kill(3); kill(6); kill(7);
    check("cols_vivos", vivos, 8'h33);
    begin
      int guard = 0;
      do begin
        wait_passo(n);
        guard++;
      end while (y == 40 && guard < 60);
    end
    check("narrow_desc_x", x, 560);
    check("narrow_desc_y", y, 60);
    wait_passo(n);
    check("narrow_period", n, 2);
    check("narrow_left_x", x, 540);

    // Speed-up per kill: periods 4, 3, 3 (repeat kill), 2, 2.
    restart(40, 40);
    wait_passo(n);
    check("spd_p4", n, 4);
    kill(0);
    wait_passo(n);
    check("spd_p3", n + 1, 3);
    kill(0);
    wait_passo(n);
    check("spd_repeat_p3", n + 1, 3);
    check("spd_repeat_vivos", vivos, 8'hFE);
    kill(1);
    wait_passo(n);
    check("spd_p2", n + 1, 2);
    kill(2);
    wait_passo(n);
    check("spd_floor_p2", n + 1, 2);
    check("spd_vivos", vivos, 8'hF8);

    // Pause mid-count freezes counter, motion and hits.
    restart(40, 40);
    wait_passo(n);
    check("pause_pre_x", x, 60);
    @(negedge clk);
    pausa  = 1'b1;
    idx    = 3'd5;
    acerto = 1'b1;
    expect_idle("pause_idle", 10);
    check("pause_x", x, 60);
    check("pause_vivos", vivos, 8'hFF);
    acerto = 1'b0;
    pausa  = 1'b0;
    wait_passo(n);
    check("pause_resume_cycles", n, 3);
    check("pause_resume_x", x, 80);

    // Kill coincident with the right-boundary tick uses the pre-kill mask.
    restart(480, 40);
    kill(7);
    @(negedge clk);
    idx    = 3'd3;
    acerto = 1'b1;
    @(negedge clk);
    acerto = 1'b0;
    check("coinc_passo", passo, 1);
    check("coinc_x", x, 480);
    check("coinc_y", y, 60);
    check("coinc_vivos", vivos, 8'h77);
    wait_passo(n);
    check("coinc_left_x", x, 460);

    // Invasion line: bottom row edge at 439 then 440.
    restart(40, 369);
    wait_passo(n);
    check("fundo_439", fundo, 0);
    check("fundo_439_x", x, 60);
    restart(40, 370);
    check("fundo_clr", fundo, 0);
    wait_passo(n);
    check("fundo_440", fundo, 1);
    check("fundo_440_x", x, 60);
    expect_idle("fundo_halt", 20);
    check("fundo_halt_x", x, 60);

    // Async reset mid-count, no clock edge needed.
    #2 reset = 1'b1;
    #1;
    check("arst_x", x, 40);
    check("arst_y", y, 40);
    check("arst_fundo", fundo, 0);
    check("arst_passo", passo, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_passo(n);
    check("arst_first_period", n, 4);
    check("arst_first_x", x, 60);

    // Empty formation stops motion.
    restart(40, 40);
    for (int i = 0; i < 8; i++) kill(i);
    check("empty_vivos", vivos, 0);
    check("empty_vazia", vazia, 1);
    check("empty_x", x, 100);
    expect_idle("empty_halt", 20);
    check("empty_halt_x", x, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
